dac_iq_stream_scheduler: RTL

- Sequences the dual-channel interleaved IQ DAC output stage.
- Accepts two independent valid/ready sample streams (ch1, ch2) and buffers each in a small FIFO.
- Holds the DAC IQ reset for a programmed window, primes both buffers, then presents one aligned ch1/ch2 sample pair per cycle to the DDR output stage.
- Substitutes an idle code on underflow, flags it, and supports on-the-fly resynchronisation.

---
 rtl/dac_iq_stream_scheduler_if.sv | 28 ++
 rtl/dac_iq_stream_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dac_iq_stream_scheduler_if.sv
// Sample stream bus of the IQ DAC scheduler: two valid/ready inputs and the
// aligned pair of registered DAC outputs.
interface dac_iq_stream_scheduler_if #(
    parameter int unsigned INT_DAC_DATA_WIDTH = 10
);
    logic [INT_DAC_DATA_WIDTH-1:0] in_data_ch1;
    logic [INT_DAC_DATA_WIDTH-1:0] in_data_ch2;
    logic                          in_valid_ch1;
    logic                          in_valid_ch2;
    logic                          out_ready_ch1;
    logic                          out_ready_ch2;
    logic [INT_DAC_DATA_WIDTH-1:0] out_dac_data_ch1;
    logic [INT_DAC_DATA_WIDTH-1:0] out_dac_data_ch2;
    logic                          out_valid_ch1;
    logic                          out_valid_ch2;

    modport master (
        output in_data_ch1, in_data_ch2, in_valid_ch1, in_valid_ch2,
        input  out_ready_ch1, out_ready_ch2,
        input  out_dac_data_ch1, out_dac_data_ch2, out_valid_ch1, out_valid_ch2
    );

    modport slave (
        input  in_data_ch1, in_data_ch2, in_valid_ch1, in_valid_ch2,
        output out_ready_ch1, out_ready_ch2,
        output out_dac_data_ch1, out_dac_data_ch2, out_valid_ch1, out_valid_ch2
    );
endinterface

// File: rtl/dac_iq_stream_scheduler.sv
// Dual-channel IQ DAC output sequencer: IQ reset window, FIFO priming, aligned
// pair playout with underflow substitution and resynchronisation.
module dac_iq_stream_scheduler #(
    parameter int unsigned INT_DAC_DATA_WIDTH = 10,
    parameter int unsigned INT_FIFO_DEPTH     = 4,
    parameter int unsigned INT_PRIME_LEVEL    = 2,
    parameter int unsigned INT_IQRST_CYCLES   = 4,
    parameter bit          BIT_UNDERFLOW_HOLD = 1'b0
) (
    input  logic                       in_clk_data,
    input  logic                       in_rst_n,
    input  logic                       in_en_ch1,
    input  logic                       in_en_ch2,
    input  logic                       in_resync,
    input  logic                       in_clear_flags,
    dac_iq_stream_scheduler_if.slave   bus,
    output logic                       out_dac_rst,
    output logic                       out_running,
    output logic                       out_underflow_ch1,
    output logic                       out_underflow_ch2,
    output logic [15:0]                out_underflow_count
);
    localparam int unsigned W  = INT_DAC_DATA_WIDTH;
    localparam int unsigned AW = $clog2(INT_FIFO_DEPTH);
    localparam int unsigned CW = $clog2(INT_FIFO_DEPTH + 1);
    localparam int unsigned HW = $clog2(INT_IQRST_CYCLES + 1);
    localparam logic [W-1:0] IDLE_CODE = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {RST_HOLD, PRIME, RUN} state_t;

    state_t        state, state_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [1:0]    en, in_valid, ready, level_ok, uf_now, uf_flag, dac_valid;
    logic [W-1:0]  in_data  [2];
    logic [W-1:0]  dac_data [2];
    logic          prime_ok, run_act;
    logic [15:0]   uf_count;

    assign en          = {in_en_ch2, in_en_ch1};
    assign in_valid    = {bus.in_valid_ch2, bus.in_valid_ch1};
    assign in_data[0]  = bus.in_data_ch1;
    assign in_data[1]  = bus.in_data_ch2;
    assign prime_ok    = (|en) & (&(level_ok | ~en));
    assign run_act     = (state == RUN) & ~in_resync;

    // Next-state logic; a resync overrides everything and reloads the hold window
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        if (in_resync) begin
            state_next = RST_HOLD;
            hold_next  = HW'(INT_IQRST_CYCLES);
        end else begin
            case (state)
                RST_HOLD: begin
                    if (hold_cnt <= HW'(1)) state_next = PRIME;
                    else                    hold_next  = hold_cnt - HW'(1);
                end
                PRIME:   if (prime_ok) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = RST_HOLD;
            endcase
        end
    end

    always_ff @(posedge in_clk_data or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state       <= RST_HOLD;
            hold_cnt    <= HW'(INT_IQRST_CYCLES);
            out_dac_rst <= 1'b1;
            out_running <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            out_dac_rst <= (state_next == RST_HOLD);
            out_running <= (state_next == RUN);
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [W-1:0]  mem [INT_FIFO_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0] level;
        logic [W-1:0]  data_q;
        logic          valid_q, is_empty, is_full, flush, push, pop;

        assign is_empty    = (level == '0);
        assign is_full     = (level == CW'(INT_FIFO_DEPTH));
        assign flush       = in_resync | (state == RST_HOLD) | ~en[c];
        assign ready[c]    = en[c] & (state != RST_HOLD) & ~is_full;
        assign push        = in_valid[c] & ready[c];
        assign pop         = run_act & en[c] & ~is_empty;
        assign uf_now[c]   = run_act & en[c] & is_empty;
        assign level_ok[c] = (level >= CW'(INT_PRIME_LEVEL));

        // Flush wins over any push/pop landing in the same cycle
        always_ff @(posedge in_clk_data or negedge in_rst_n) begin
            if (!in_rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + CW'(push) - CW'(pop);
            end
        end

        always_ff @(posedge in_clk_data) begin
            if (push) mem[wr_ptr] <= in_data[c];
        end

        // Output stage: FIFO head on pop, substitute value on underflow
        always_ff @(posedge in_clk_data or negedge in_rst_n) begin
            if (!in_rst_n) begin
                data_q  <= IDLE_CODE;
                valid_q <= 1'b0;
            end else if (!en[c] || !run_act) begin
                data_q  <= IDLE_CODE;
                valid_q <= 1'b0;
            end else if (!is_empty) begin
                data_q  <= mem[rd_ptr];
                valid_q <= 1'b1;
            end else begin
                data_q  <= BIT_UNDERFLOW_HOLD ? data_q : IDLE_CODE;
                valid_q <= 1'b0;
            end
        end

        assign dac_data[c]  = data_q;
        assign dac_valid[c] = valid_q;
    end

    // Sticky flags and saturating counter; a new underflow beats a clear
    always_ff @(posedge in_clk_data or negedge in_rst_n) begin
        if (!in_rst_n) begin
            uf_flag  <= '0;
            uf_count <= '0;
        end else begin
            uf_flag <= (uf_flag & ~{2{in_clear_flags}}) | uf_now;
            if (|uf_now) begin
                if (in_clear_flags)             uf_count <= 16'd1;
                else if (uf_count != 16'hFFFF)  uf_count <= uf_count + 16'd1;
            end else if (in_clear_flags) begin
                uf_count <= '0;
            end
        end
    end

    assign bus.out_ready_ch1    = ready[0];
    assign bus.out_ready_ch2    = ready[1];
    assign bus.out_dac_data_ch1 = dac_data[0];
    assign bus.out_dac_data_ch2 = dac_data[1];
    assign bus.out_valid_ch1    = dac_valid[0];
    assign bus.out_valid_ch2    = dac_valid[1];
    assign out_underflow_ch1    = uf_flag[0];
    assign out_underflow_ch2    = uf_flag[1];
    assign out_underflow_count  = uf_count;
endmodule
